// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   REG_AW      : register-address width
//   FWD_*       : forwarding-mux select codes (00 RF, 10 EX/MEM, 01 MEM/WB)
//   REG_ZERO    : hard-wired zero register, never a forwarding source
//   pipe_slot_t : shadow of one in-flight instruction {dest, regwrite, memread}
//   slot_writes : true when a slot will write a non-zero register equal to r
package mips_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
  } pipe_slot_t;

  function automatic logic slot_writes(input pipe_slot_t s, input logic [REG_AW-1:0] r);
    return s.regwrite && (s.dest != REG_ZERO) && (s.dest == r);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// fwd_select: priority compare of one ALU source register against the
// MEM and WB shadow slots, producing one forwarding-mux select.
// Ports:
//   src      in  source register of the instruction in EX
//   mem_slot in  shadow of the instruction in MEM
//   wb_slot  in  shadow of the instruction in WB
//   sel      out mux select (FWD_RF / FWD_EXMEM / FWD_MEMWB, never 11)
module fwd_select
  import mips_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  pipe_slot_t        mem_slot,
  input  pipe_slot_t        wb_slot,
  output logic [1:0]        sel
);

  // Load/ALU distinction does not matter for forwarding.
  logic unused_memread;
  assign unused_memread = mem_slot.memread ^ wb_slot.memread;

  // The MEM producer is younger than the WB producer, so it wins.
  always_comb begin
    sel = FWD_RF;
    if (slot_writes(mem_slot, src)) begin
      sel = FWD_EXMEM;
    end else if (slot_writes(wb_slot, src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: forwarding and load-use hazard control for the
// 5-stage MIPS datapath. Shadows dest/regwrite/memread of the EX, MEM and
// WB instructions (plus rs/rt of EX) and drives the ALU operand mux selects
// and the PC / IF/ID hold and ID/EX bubble controls.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid            ID stage holds a real instruction
//   id_rs, id_rt        ID source registers
//   id_dest             ID destination (after RegDst mux)
//   id_regwrite         ID instruction writes the register file
//   id_memread          ID instruction is a load
//   id_branch           ID instruction is a branch compared in ID
//   flush               kill the ID instruction (taken branch/jump)
//   fwd_a, fwd_b        operand-A/B forwarding selects for the EX instruction
//   pc_hold, ifid_hold  hold PC / IF/ID register
//   idex_bubble         load a bubble into ID/EX
// Configuration macro HAZARD_BRANCH_ID_EN: when defined, branches resolved in
// ID also stall on a matching producer in EX, or a load in MEM; otherwise
// id_branch is ignored.
// REG_AW must equal mips_pipe_pkg::REG_AW, which sizes the shadow slots.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_branch,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_bubble
);

  import mips_pipe_pkg::pipe_slot_t;
  import mips_pipe_pkg::slot_writes;

  pipe_slot_t        slot_ex_p0;
  pipe_slot_t        slot_mem_p1;
  pipe_slot_t        slot_wb_p2;
  logic [REG_AW-1:0] ex_rs_p0;
  logic [REG_AW-1:0] ex_rt_p0;

  logic id_live;
  logic lu;
  logic stall;

  // The ID instruction is treated as invalid while reset is asserted, which
  // forces a bubble and keeps the hold outputs low.
  assign id_live = id_valid && rst_n;

  assign lu = id_live && slot_ex_p0.memread &&
              (slot_writes(slot_ex_p0, id_rs) || slot_writes(slot_ex_p0, id_rt));

`ifdef HAZARD_BRANCH_ID_EN
  logic [1:0] br_cnt;
  logic       br_ex;
  logic       br_mem;

  // The branch comparator sits in ID and has no path from EX, nor from a
  // load still in MEM, so those producers must drain first.
  assign br_ex  = id_live && id_branch &&
                  (slot_writes(slot_ex_p0, id_rs) || slot_writes(slot_ex_p0, id_rt));
  assign br_mem = id_live && id_branch && slot_mem_p1.memread &&
                  (slot_writes(slot_mem_p1, id_rs) || slot_writes(slot_mem_p1, id_rt));

  assign stall = lu || br_ex || br_mem || (br_cnt != 2'd0);

  // br_cnt holds the stall cycles still owed after the current one: a load
  // in EX owes one more (it must leave MEM), an ALU producer owes none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= 2'd0;
    end else if (flush) begin
      br_cnt <= 2'd0;
    end else if (br_cnt != 2'd0) begin
      br_cnt <= br_cnt - 2'd1;
    end else if (br_ex) begin
      br_cnt <= slot_ex_p0.memread ? 2'd1 : 2'd0;
    end
  end
`else
  logic unused_branch;
  assign unused_branch = id_branch;
  assign stall         = lu;
`endif

  // A flush kills the ID instruction, so a stall for it is pointless.
  assign pc_hold     = stall && !flush;
  assign ifid_hold   = stall && !flush;
  assign idex_bubble = stall || flush || !id_live;

  // ---- ID -> EX -> MEM -> WB shadow registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_ex_p0  <= '0;
      slot_mem_p1 <= '0;
      slot_wb_p2  <= '0;
      ex_rs_p0    <= '0;
      ex_rt_p0    <= '0;
    end else begin
      slot_wb_p2  <= slot_mem_p1;
      slot_mem_p1 <= slot_ex_p0;
      if (idex_bubble) begin
        slot_ex_p0 <= '0;
        ex_rs_p0   <= '0;
        ex_rt_p0   <= '0;
      end else begin
        slot_ex_p0.dest     <= id_dest;
        slot_ex_p0.regwrite <= id_regwrite;
        slot_ex_p0.memread  <= id_memread;
        ex_rs_p0            <= id_rs;
        ex_rt_p0            <= id_rt;
      end
    end
  end

  // ---- EX operand forwarding ----
  fwd_select u_fwd_a (
    .src      (ex_rs_p0),
    .mem_slot (slot_mem_p1),
    .wb_slot  (slot_wb_p2),
    .sel      (fwd_a)
  );

  fwd_select u_fwd_b (
    .src      (ex_rt_p0),
    .mem_slot (slot_mem_p1),
    .wb_slot  (slot_wb_p2),
    .sel      (fwd_b)
  );

endmodule
